// File: rtl/mc_pkg.sv
// Shared encodings for the pj1 multi-cycle control FSM: states, opcodes,
// function codes, extender/ALU modes and datapath select codes.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_SHL2 = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_REG  = 2'b11;

  localparam logic [1:0] WA_RD = 2'b00;
  localparam logic [1:0] WA_RT = 2'b01;
  localparam logic [1:0] WA_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  // Exactly one bit is set for any opcode/funct pair.
  typedef struct packed {
    logic rtype_add;
    logic rtype_sub;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps opcode/funct to a one-hot
// instruction class, flagging anything unsupported as illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.rtype_add = 1'b1;
          FN_SUBU: cls.rtype_sub = 1'b1;
          FN_JR:   cls.jr        = 1'b1;
          default: cls.illegal   = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM for the pj1 datapath, with a memory-ready stall
// and a retired-instruction counter.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int RA_IDX = 31,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             reg_we,
  output logic [1:0]       wa_sel,
  output logic [1:0]       wd_sel,
  output logic             mem_re,
  output logic             mem_we,
  output logic [1:0]       EOp,
  output logic [2:0]       alu_op,
  output logic             b_sel,
  output logic             tgt_we,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  // The datapath decodes wa_sel=10 into this register index.
  if (RA_IDX < 0 || RA_IDX > 31) begin : g_bad_ra_idx
    $error("mc_ctrl: RA_IDX must be a GPR index 0..31");
  end

  iclass_t cls;
  state_t  state_q;
  state_t  nxt;
  logic    retire;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  always_comb begin
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    npc_sel = NPC_PC4;
    reg_we  = 1'b0;
    wa_sel  = WA_RD;
    wd_sel  = WD_ALU;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    EOp     = EXT_SIGN;
    alu_op  = ALU_ADD;
    b_sel   = 1'b0;
    tgt_we  = 1'b0;
    illegal = 1'b0;
    retire  = 1'b0;
    nxt     = state_q;
    case (state_q)
      S_FETCH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          npc_sel = NPC_PC4;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target PC+(imm<<2) is computed speculatively for every instruction.
        EOp    = EXT_SHL2;
        alu_op = ALU_ADD;
        tgt_we = 1'b1;
        nxt    = S_FETCH;
        if (cls.j) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JUMP;
          retire  = 1'b1;
        end else if (cls.jal) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JUMP;
          reg_we  = 1'b1;
          wa_sel  = WA_RA;
          wd_sel  = WD_PC;
          retire  = 1'b1;
        end else if (cls.jr) begin
          pc_we   = 1'b1;
          npc_sel = NPC_REG;
          retire  = 1'b1;
        end else if (cls.illegal) begin
          illegal = 1'b1;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE: begin
        nxt = S_FETCH;
        if (cls.rtype_add || cls.rtype_sub) begin
          b_sel  = 1'b0;
          alu_op = cls.rtype_sub ? ALU_SUB : ALU_ADD;
          nxt    = S_WB;
        end else if (cls.ori) begin
          EOp    = EXT_ZERO;
          b_sel  = 1'b1;
          alu_op = ALU_OR;
          nxt    = S_WB;
        end else if (cls.lui) begin
          EOp    = EXT_LUI;
          b_sel  = 1'b1;
          alu_op = ALU_PASSB;
          nxt    = S_WB;
        end else if (cls.lw || cls.sw) begin
          EOp    = EXT_SIGN;
          b_sel  = 1'b1;
          alu_op = ALU_ADD;
          nxt    = S_MEM;
        end else if (cls.beq) begin
          alu_op  = ALU_SUB;
          pc_we   = zero;
          npc_sel = NPC_BR;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        mem_re = cls.lw;
        mem_we = cls.sw;
        if (!(cls.lw || cls.sw)) begin
          nxt = S_FETCH;
        end else if (mem_ready) begin
          if (cls.sw) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        wa_sel = (cls.rtype_add || cls.rtype_sub) ? WA_RD : WA_RT;
        wd_sel = cls.lw ? WD_MEM : WD_ALU;
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      instret <= '0;
    end else begin
      state_q <= nxt;
      if (retire) begin
        instret <= instret + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: each instruction is run to completion under a reactive
// memory model and its per-instruction footprint is compared to a reference.
module tb_mc_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  npc_sel;
  logic        reg_we;
  logic [1:0]  wa_sel;
  logic [1:0]  wd_sel;
  logic        mem_re;
  logic        mem_we;
  logic [1:0]  EOp;
  logic [2:0]  alu_op;
  logic        b_sel;
  logic        tgt_we;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  mc_ctrl #(.RA_IDX(31), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .npc_sel   (npc_sel),
    .reg_we    (reg_we),
    .wa_sel    (wa_sel),
    .wd_sel    (wd_sel),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .EOp       (EOp),
    .alu_op    (alu_op),
    .b_sel     (b_sel),
    .tgt_we    (tgt_we),
    .illegal   (illegal),
    .state     (state),
    .instret   (instret)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_instret = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  localparam int K_ADD = 0, K_SUB = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5,
                 K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

  task automatic encode(input int kind, output logic [5:0] op, output logic [5:0] fn);
    logic [5:0] ill_op[5];
    logic [5:0] ill_fn[5];
    int sel;
    ill_op = '{6'h3F, 6'h01, 6'h05, 6'h00, 6'h00};
    ill_fn = '{6'h21, 6'h00, 6'h08, 6'h20, 6'h00};
    fn = 6'($urandom_range(0, 63));
    case (kind)
      K_ADD: begin op = 6'h00; fn = 6'h21; end
      K_SUB: begin op = 6'h00; fn = 6'h23; end
      K_JR:  begin op = 6'h00; fn = 6'h08; end
      K_ORI: op = 6'h0D;
      K_LUI: op = 6'h0F;
      K_LW:  op = 6'h23;
      K_SW:  op = 6'h2B;
      K_BEQ: op = 6'h04;
      K_J:   op = 6'h02;
      K_JAL: op = 6'h03;
      default: begin
        sel = $urandom_range(0, 4);
        op = ill_op[sel];
        fn = ill_fn[sel];
      end
    endcase
  endtask

  // ---------------- driver + reference ----------------
  // Starts and ends one cycle-slot after a rising edge with the DUT in FETCH.
  task automatic run_instr(input int kind, input logic z, input int fst, input int mst);
    logic [5:0] op, fn;
    int cyc = 0, acc = 0, acc_idx = 0;
    int n_reg = 0, n_pc = 0, n_ill = 0, n_ir = 0, n_re = 0, n_we = 0, n_both = 0;
    int n_exe = 0, n_mem = 0, n_wb = 0;
    logic [1:0] wa_o = 0, wd_o = 0, npc_o = 0, eop_dec = 0, eop_exe = 0;
    logic [2:0] alu_exe = 0;
    logic bsel_exe = 0;
    logic left_fetch = 0, done = 0;
    int exp_cyc, exp_reg, exp_pc, stall_lim;
    bit is_r, is_jump, is_mem, writes;
    string t;

    encode(kind, op, fn);
    opcode = op;
    funct  = fn;
    zero   = z;
    while (!done && cyc < 40) begin
      stall_lim = (acc_idx == 0) ? fst : mst;
      if (mem_re || mem_we) mem_ready = (acc >= stall_lim);
      else                  mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (reg_we) begin n_reg++; wa_o = wa_sel; wd_o = wd_sel; end
      if (pc_we) begin
        n_pc++;
        if (state != 3'd0) npc_o = npc_sel;
      end
      if (illegal) n_ill++;
      if (ir_we) n_ir++;
      if (mem_re) n_re++;
      if (mem_we) n_we++;
      if (mem_re && mem_we) n_both++;
      if (state == 3'd1) eop_dec = EOp;
      if (state == 3'd2) begin n_exe++; eop_exe = EOp; alu_exe = alu_op; bsel_exe = b_sel; end
      if (state == 3'd3) n_mem++;
      if (state == 3'd4) n_wb++;
      if (state != 3'd0) left_fetch = 1;
      if (mem_re || mem_we) begin
        if (mem_ready) begin acc = 0; acc_idx++; end
        else acc++;
      end
      cyc++;
      @(posedge clk);
      #1;
      if (left_fetch && state == 3'd0) done = 1;
    end
    t = $sformatf("k%0d", kind);
    if (!done) check_val({t, "_timeout"}, 32'd1, 32'd0);

    is_r    = (kind == K_ADD || kind == K_SUB);
    is_jump = (kind == K_J || kind == K_JAL || kind == K_JR);
    is_mem  = (kind == K_LW || kind == K_SW);
    writes  = is_r || kind == K_ORI || kind == K_LUI || kind == K_LW || kind == K_JAL;

    if (is_jump || kind == K_ILL) exp_cyc = 2;
    else if (kind == K_BEQ)       exp_cyc = 3;
    else if (kind == K_LW)        exp_cyc = 5;
    else                          exp_cyc = 4;
    exp_cyc += fst + (is_mem ? mst : 0);
    exp_reg = writes ? 1 : 0;
    exp_pc  = 1 + (is_jump ? 1 : 0) + ((kind == K_BEQ && z) ? 1 : 0);
    if (kind != K_ILL) exp_instret = exp_instret + 1;
    exp_q.push_back(exp_instret);

    check_val({t, "_cycles"}, cyc, exp_cyc);
    check_val({t, "_reg_we_cnt"}, n_reg, exp_reg);
    check_val({t, "_pc_we_cnt"}, n_pc, exp_pc);
    check_val({t, "_ir_we_cnt"}, n_ir, 1);
    check_val({t, "_illegal_cnt"}, n_ill, (kind == K_ILL) ? 1 : 0);
    check_val({t, "_mem_re_cyc"}, n_re, fst + 1 + ((kind == K_LW) ? mst + 1 : 0));
    check_val({t, "_mem_we_cyc"}, n_we, (kind == K_SW) ? mst + 1 : 0);
    check_val({t, "_re_we_both"}, n_both, 0);
    check_val({t, "_eop_decode"}, eop_dec, 2'b11);
    check_val({t, "_exe_visits"}, n_exe, (is_jump || kind == K_ILL) ? 0 : 1);
    check_val({t, "_mem_visits"}, n_mem, is_mem ? mst + 1 : 0);
    check_val({t, "_wb_visits"}, n_wb, (writes && kind != K_JAL) ? 1 : 0);
    check_val({t, "_instret"}, instret, exp_q.pop_front());
    if (writes) begin
      check_val({t, "_wa_sel"}, wa_o, kind == K_JAL ? 2'b10 : (is_r ? 2'b00 : 2'b01));
      check_val({t, "_wd_sel"}, wd_o, kind == K_JAL ? 2'b10 : (kind == K_LW ? 2'b01 : 2'b00));
    end
    if (is_jump || (kind == K_BEQ && z))
      check_val({t, "_npc_sel"}, npc_o, kind == K_JR ? 2'b11 : (kind == K_BEQ ? 2'b01 : 2'b10));
    if (n_exe > 0 && !is_jump && kind != K_ILL) begin
      case (kind)
        K_ORI: begin
          check_val({t, "_exe_eop"}, eop_exe, 2'b01);
          check_val({t, "_exe_alu"}, alu_exe, 3'b010);
        end
        K_LUI: begin
          check_val({t, "_exe_eop"}, eop_exe, 2'b10);
          check_val({t, "_exe_alu"}, alu_exe, 3'b011);
        end
        K_SUB, K_BEQ: check_val({t, "_exe_alu"}, alu_exe, 3'b001);
        default: begin
          check_val({t, "_exe_eop"}, eop_exe, 2'b00);
          check_val({t, "_exe_alu"}, alu_exe, 3'b000);
        end
      endcase
      check_val({t, "_exe_bsel"}, bsel_exe, (is_r || kind == K_BEQ) ? 1'b0 : 1'b1);
    end
  endtask

  // Drives a sw into MEM, stalls it, then drops reset mid-access.
  task automatic reset_mid_sw();
    opcode = 6'h2B;
    funct  = 6'h00;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    check_val("pre_reset_state_mem", state, 3'd3);
    check_val("pre_reset_mem_we", mem_we, 1'b1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_val("rst_async_state", state, 3'd0);
    check_val("rst_async_mem_we", mem_we, 1'b0);
    check_val("rst_async_mem_re", mem_re, 1'b1);
    check_val("rst_async_instret", instret, 32'd0);
    @(posedge clk); #1;
    check_val("rst_held_state", state, 3'd0);
    check_val("rst_held_ir_we", ir_we, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    exp_instret = 0;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_state", state, 3'd0);
    check_val("reset_mem_re", mem_re, 1'b1);
    check_val("reset_mem_we", mem_we, 1'b0);
    check_val("reset_instret", instret, 32'd0);
    check_val("reset_pc_we", pc_we, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    run_instr(K_ADD, 1'b0, 0, 0);
    run_instr(K_ORI, 1'b0, 0, 0);
    run_instr(K_LUI, 1'b0, 0, 0);
    run_instr(K_BEQ, 1'b1, 0, 0);
    run_instr(K_BEQ, 1'b0, 0, 0);
    run_instr(K_LW,  1'b0, 0, 3);
    run_instr(K_JAL, 1'b0, 0, 0);
    run_instr(K_ILL, 1'b0, 0, 0);
    run_instr(K_SUB, 1'b1, 1, 0);
    run_instr(K_JR,  1'b0, 2, 0);
    run_instr(K_J,   1'b1, 0, 0);
    run_instr(K_SW,  1'b0, 1, 2);

    reset_mid_sw();

    for (int i = 0; i < 80; i++) begin
      run_instr($urandom_range(0, 10), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
